// File: rtl/mem_fill_arbiter_pkg.sv
// Shared types for the memory fill arbiter: FSM state encoding, arbitration modes, clog2 helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_fill_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Ceiling log2, never below 1 so single-entry selects still get a real bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_fill_arbiter_if.sv
// Bundle of channel-request, response and main-memory signals around the fill arbiter.
// Latency: n/a (wiring only).
// Backpressure: level req held by the cache until rsp_done; memory side has none.
// Ports: master = arbiter (drives busy/rsp_*/mem_* strobes), slave = caches + memory.
interface mem_fill_arbiter_if #(
    parameter int NCH         = 2,
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int BLOCK_WORDS = 8
) ();
    import mem_fill_arbiter_pkg::*;

    localparam int CW = clog2(NCH);
    localparam int IW = clog2(BLOCK_WORDS);

    logic [NCH-1:0]    req;
    logic [NCH-1:0]    req_wr;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata;
    logic [NCH-1:0]    busy;
    logic              rsp_valid;
    logic [CW-1:0]     rsp_ch;
    logic [IW-1:0]     rsp_idx;
    logic [DW-1:0]     rsp_data;
    logic              rsp_done;
    logic              mem_en;
    logic              mem_wr;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              mem_data_valid;

    modport master (
        input  req, req_wr, req_addr, req_wdata, mem_rdata, mem_data_valid,
        output busy, rsp_valid, rsp_ch, rsp_idx, rsp_data, rsp_done,
               mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        output req, req_wr, req_addr, req_wdata, mem_rdata, mem_data_valid,
        input  busy, rsp_valid, rsp_ch, rsp_idx, rsp_data, rsp_done,
               mem_en, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_fill_arbiter_rr_arbiter.sv
// Request arbiter: fixed lowest-index priority, or round-robin starting at ptr.
// Latency: combinational, req/ptr -> one-hot grant in the same cycle.
// Backpressure: none; grant is only consumed by the owner FSM while idle.
// Ports: req (NCH) + ptr (clog2 NCH) in, grant (NCH, one-hot or zero) out.
module rr_arbiter
    import mem_fill_arbiter_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int RR_MODE = ARB_FIXED
) (
    input  logic [NCH-1:0]         req,
    input  logic [clog2(NCH)-1:0]  ptr,
    output logic [NCH-1:0]         grant
);

    localparam int CW = clog2(NCH);

    logic [CW-1:0] start;
    logic [CW-1:0] idx;
    logic          found;
    int            pos;

    always_comb begin
        grant = '0;
        found = 1'b0;
        pos   = 0;
        idx   = '0;
        // Fixed mode is round-robin with the search always starting at channel 0.
        start = (RR_MODE == ARB_RR) ? ptr : '0;
        for (int i = 0; i < NCH; i++) begin
            pos = int'(start) + i;
            if (pos >= NCH) pos = pos - NCH;
            idx = CW'(pos);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates NCH cache channels onto one pipelined main memory: block refills and write-through stores.
// Latency: grant+1 to first issue; refill done BLOCK_WORDS+MEM_LAT cycles after first issue; write done in 1.
// Backpressure: losing channels wait with req held; busy[ch] stalls the owning cache; no preemption.
// Ports: clk, rst (async active-high), bus (master modport: req/rsp channel side + mem side).
module mem_fill_arbiter
    import mem_fill_arbiter_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LAT     = 4,
    parameter int RR_MODE     = ARB_FIXED
) (
    input  logic               clk,
    input  logic               rst,
    mem_fill_arbiter_if.master bus
);

    localparam int              CW   = clog2(NCH);
    localparam int              IW   = clog2(BLOCK_WORDS);
    localparam int              OFF  = clog2(BLOCK_WORDS * DW / 8);
    localparam logic [AW-1:0]   STEP = AW'(DW / 8);
    localparam logic [IW-1:0]   LAST = IW'(BLOCK_WORDS - 1);

    state_t         state;
    logic [NCH-1:0] busy_q;
    logic           mem_en_q;
    logic           mem_wr_q;
    logic [AW-1:0]  mem_addr_q;
    logic [DW-1:0]  mem_wdata_q;
    logic [CW-1:0]  lat_ch;
    logic [CW-1:0]  rr_ptr;
    logic [IW-1:0]  issue_cnt;
    logic [IW-1:0]  ret_cnt;

    logic [NCH-1:0] grant;
    logic [CW-1:0]  win_idx;
    logic           win_wr;
    logic [AW-1:0]  win_addr;
    logic [DW-1:0]  win_wdata;
    logic           ret_ok;
    logic           ret_last;
    logic [CW-1:0]  ptr_next;

    rr_arbiter #(
        .NCH     (NCH),
        .RR_MODE (RR_MODE)
    ) u_arb (
        .req   (bus.req),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        win_idx   = '0;
        win_wr    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                win_idx   = CW'(i);
                win_wr    = bus.req_wr[i];
                win_addr  = bus.req_addr[i*AW +: AW];
                win_wdata = bus.req_wdata[i*DW +: DW];
            end
        end
    end

    // A genuine return cannot precede the MEM_LAT-th issue, so earlier strobes
    // during ISSUE are stray and dropped along with those in IDLE/WRITE.
    assign ret_ok   = bus.mem_data_valid &&
                      ((state == ST_DRAIN) ||
                       ((state == ST_ISSUE) && (int'(issue_cnt) >= MEM_LAT)));
    assign ret_last = ret_ok && (ret_cnt == LAST);
    assign ptr_next = (lat_ch == CW'(NCH - 1)) ? '0 : lat_ch + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lat_ch      <= '0;
            rr_ptr      <= '0;
            issue_cnt   <= '0;
            ret_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        lat_ch    <= win_idx;
                        busy_q    <= grant;
                        mem_en_q  <= 1'b1;
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                        if (win_wr) begin
                            state       <= ST_WRITE;
                            mem_wr_q    <= 1'b1;
                            mem_addr_q  <= win_addr;
                            mem_wdata_q <= win_wdata;
                        end else begin
                            state      <= ST_ISSUE;
                            mem_wr_q   <= 1'b0;
                            mem_addr_q <= {win_addr[AW-1:OFF], {OFF{1'b0}}};
                        end
                    end
                end
                ST_ISSUE: begin
                    if (ret_ok) ret_cnt <= ret_cnt + 1'b1;
                    if (issue_cnt == LAST) begin
                        state      <= ST_DRAIN;
                        mem_en_q   <= 1'b0;
                        mem_addr_q <= '0;
                    end else begin
                        issue_cnt  <= issue_cnt + 1'b1;
                        mem_addr_q <= mem_addr_q + STEP;
                    end
                end
                ST_DRAIN: begin
                    if (ret_last) begin
                        state  <= ST_IDLE;
                        busy_q <= '0;
                        rr_ptr <= ptr_next;
                    end else if (ret_ok) begin
                        ret_cnt <= ret_cnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    state       <= ST_IDLE;
                    busy_q      <= '0;
                    mem_en_q    <= 1'b0;
                    mem_wr_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    rr_ptr      <= ptr_next;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Return path is combinational so the cache sees each word in its return cycle.
    assign bus.rsp_valid = ret_ok;
    assign bus.rsp_done  = ret_last || (state == ST_WRITE);
    assign bus.rsp_idx   = ret_ok ? ret_cnt : '0;
    assign bus.rsp_data  = ret_ok ? bus.mem_rdata : '0;
    assign bus.rsp_ch    = (ret_ok || bus.rsp_done) ? lat_ch : '0;

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter: fixed-priority instance driven from a vector table plus corner sequences,
// and a round-robin instance for grant ordering. Each instance has its own pipelined memory model.
// Memory returns word(addr) = addr ^ 16'hC3A5 exactly MEM_LAT cycles after a read issue.
module tb_mem_fill_arbiter;
    import mem_fill_arbiter_pkg::*;

    localparam int NCH = 2;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int BW  = 8;
    localparam int LAT = 4;

    logic clk;
    logic rst;
    logic spur_fx;

    int n_cmp;
    int n_bad;

    mem_fill_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW), .BLOCK_WORDS(BW)) bus_fx ();
    mem_fill_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW), .BLOCK_WORDS(BW)) bus_rr ();

    mem_fill_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .BLOCK_WORDS(BW), .MEM_LAT(LAT),
                       .RR_MODE(ARB_FIXED)) dut_fx (.clk(clk), .rst(rst), .bus(bus_fx));
    mem_fill_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .BLOCK_WORDS(BW), .MEM_LAT(LAT),
                       .RR_MODE(ARB_RR))    dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Pipelined memory models
    logic [LAT-1:0] fx_v, rr_v;
    logic [15:0]    fx_a [LAT];
    logic [15:0]    rr_a [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fx_v <= '0;
            rr_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                fx_a[i] <= '0;
                rr_a[i] <= '0;
            end
        end else begin
            fx_v    <= {fx_v[LAT-2:0], bus_fx.mem_en & ~bus_fx.mem_wr};
            rr_v    <= {rr_v[LAT-2:0], bus_rr.mem_en & ~bus_rr.mem_wr};
            fx_a[0] <= bus_fx.mem_addr;
            rr_a[0] <= bus_rr.mem_addr;
            for (int i = 1; i < LAT; i++) begin
                fx_a[i] <= fx_a[i-1];
                rr_a[i] <= rr_a[i-1];
            end
        end
    end

    assign bus_fx.mem_data_valid = fx_v[LAT-1] | spur_fx;
    assign bus_fx.mem_rdata      = mem_word(fx_a[LAT-1]);
    assign bus_rr.mem_data_valid = rr_v[LAT-1];
    assign bus_rr.mem_rdata      = mem_word(rr_a[LAT-1]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          ch;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_addr;   // first mem_addr: aligned base for refill, raw addr for write
        int          exp_cyc;    // busy cycles == cycle of rsp_done counted from 1
        int          drop_at;    // cycle index at which req is released early (-1 = never)
        bit          spur_idle;  // pulse mem_data_valid while idle first
    } vec_t;

    // One transaction on the fixed-priority instance, starting and ending at a negedge in IDLE.
    task automatic run_txn(input vec_t v);
        int  k;
        int  r;
        int  bcnt;
        int  done_n;
        logic [NCH-1:0] onehot;
        onehot = '0;
        onehot[v.ch] = 1'b1;
        if (v.spur_idle) begin
            spur_fx = 1'b1;
            #1;
            check("spur_idle_valid", 32'(bus_fx.rsp_valid), 0);
            check("spur_idle_done", 32'(bus_fx.rsp_done), 0);
            @(negedge clk);
            spur_fx = 1'b0;
            check("spur_idle_busy", 32'(bus_fx.busy), 0);
        end
        bus_fx.req_wr[v.ch]             = v.wr;
        bus_fx.req_addr[v.ch*AW +: AW]  = v.addr;
        bus_fx.req_wdata[v.ch*DW +: DW] = v.wdata;
        bus_fx.req[v.ch]                = 1'b1;
        k = 0; r = 0; bcnt = 0; done_n = -1;
        for (int n = 0; n < 40 && done_n < 0; n++) begin
            @(negedge clk);
            if (n == 0) check("busy_rise", 32'(bus_fx.busy), 32'(onehot));
            if (bus_fx.busy == onehot) bcnt++;
            if (bus_fx.mem_en && !bus_fx.mem_wr) begin
                check("issue_addr", 32'(bus_fx.mem_addr), 32'(v.exp_addr + 16'(2 * k)));
                check("issue_slot", n, k);
                k++;
            end
            if (bus_fx.mem_en && bus_fx.mem_wr) begin
                check("wr_addr", 32'(bus_fx.mem_addr), 32'(v.exp_addr));
                check("wr_data", 32'(bus_fx.mem_wdata), 32'(v.wdata));
            end
            if (bus_fx.rsp_valid) begin
                check("rsp_idx", 32'(bus_fx.rsp_idx), r);
                check("rsp_data", 32'(bus_fx.rsp_data), 32'(mem_word(v.exp_addr + 16'(2 * r))));
                r++;
            end
            if (bus_fx.rsp_done) begin
                check("done_ch", 32'(bus_fx.rsp_ch), v.ch);
                done_n = n;
                bus_fx.req[v.ch] = 1'b0;
            end
            if (n == v.drop_at) bus_fx.req[v.ch] = 1'b0;
        end
        check("done_cycle", done_n, v.exp_cyc - 1);
        check("busy_cycles", bcnt, v.exp_cyc);
        check("issue_count", k, v.wr ? 0 : BW);
        check("return_count", r, v.wr ? 0 : BW);
        @(negedge clk);
        check("idle_after", 32'({bus_fx.busy, bus_fx.mem_en, bus_fx.rsp_valid, bus_fx.rsp_done}), 0);
    endtask

    vec_t vecs[6];
    vec_t v5;
    int   b0, done0, g1, overlap, found, ndone;
    int   order[4];
    int   exp_order[4];

    initial begin
        // ch, wr, addr, wdata, exp_addr, exp_cyc, drop_at, spur_idle
        vecs[0] = '{0, 1'b0, 16'h0036, 16'h0000, 16'h0030, 12, -1, 1'b0};
        vecs[1] = '{1, 1'b1, 16'h0102, 16'h1234, 16'h0102,  1, -1, 1'b0};
        vecs[2] = '{1, 1'b0, 16'h00FF, 16'h0000, 16'h00F0, 12, -1, 1'b0};
        vecs[3] = '{0, 1'b1, 16'h0031, 16'hBEEF, 16'h0031,  1, -1, 1'b0};
        vecs[4] = '{0, 1'b0, 16'hFFFE, 16'h0000, 16'hFFF0, 12,  3, 1'b1};
        vecs[5] = '{1, 1'b0, 16'h0010, 16'h0000, 16'h0010, 12, -1, 1'b1};
        exp_order = '{0, 1, 0, 1};

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        spur_fx = 1'b0;
        bus_fx.req = '0; bus_fx.req_wr = '0; bus_fx.req_addr = '0; bus_fx.req_wdata = '0;
        bus_rr.req = '0; bus_rr.req_wr = '0; bus_rr.req_addr = '0; bus_rr.req_wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_fx_ctl", 32'({bus_fx.busy, bus_fx.mem_en, bus_fx.mem_wr, bus_fx.rsp_valid, bus_fx.rsp_done}), 0);
        check("rst_fx_addr", 32'(bus_fx.mem_addr), 0);
        check("rst_rr_ctl", 32'({bus_rr.busy, bus_rr.mem_en, bus_rr.mem_wr, bus_rr.rsp_valid, bus_rr.rsp_done}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_fx", 32'({bus_fx.busy, bus_fx.mem_en, bus_fx.rsp_ch, bus_fx.rsp_idx}), 0);

        // Table-driven single-channel transactions
        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Fixed priority: both channels request together
        bus_fx.req_wr = 2'b10;
        bus_fx.req_addr = {16'h0200, 16'h0040};
        bus_fx.req_wdata = {16'h5555, 16'h0000};
        bus_fx.req = 2'b11;
        b0 = -1; done0 = -1; g1 = -1; overlap = 0;
        for (int n = 1; n <= 40 && g1 < 0; n++) begin
            @(negedge clk);
            if (bus_fx.busy == 2'b11) overlap = 1;
            if (bus_fx.busy[0] && b0 < 0) b0 = n;
            if (bus_fx.rsp_done && bus_fx.rsp_ch == 1'b0 && done0 < 0) begin
                done0 = n;
                bus_fx.req[0] = 1'b0;
            end
            if (bus_fx.busy[1] && g1 < 0) begin
                g1 = n;
                check("prio_ch1_wr", 32'({bus_fx.mem_en, bus_fx.mem_wr}), 32'h3);
                check("prio_ch1_addr", 32'(bus_fx.mem_addr), 32'h0200);
                check("prio_ch1_done", 32'({bus_fx.rsp_done, bus_fx.rsp_ch}), 32'h3);
                bus_fx.req[1] = 1'b0;
            end
        end
        check("prio_ch0_first", b0, 1);
        check("prio_ch0_done", done0, 12);
        check("prio_ch1_grant", g1, 14);
        check("prio_no_overlap", overlap, 0);
        @(negedge clk);

        // Round-robin: both held for four transactions
        bus_rr.req_wr = 2'b01;
        bus_rr.req_addr = {16'h0080, 16'h0010};
        bus_rr.req_wdata = {16'h0000, 16'h1111};
        bus_rr.req = 2'b11;
        order = '{-1, -1, -1, -1};
        ndone = 0; overlap = 0;
        for (int n = 0; n < 80 && ndone < 4; n++) begin
            @(negedge clk);
            if (bus_rr.busy == 2'b11) overlap = 1;
            if (bus_rr.rsp_done) begin
                order[ndone] = int'(bus_rr.rsp_ch);
                ndone++;
            end
        end
        bus_rr.req = 2'b00;
        for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), order[i], exp_order[i]);
        check("rr_no_overlap", overlap, 0);
        repeat (14) @(negedge clk);
        check("rr_idle", 32'({bus_rr.busy, bus_rr.mem_en}), 0);

        // Reset in the middle of a refill, at issue k=3
        bus_fx.req_wr[0] = 1'b0;
        bus_fx.req_addr[15:0] = 16'h0100;
        bus_fx.req[0] = 1'b1;
        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            @(negedge clk);
            if (bus_fx.mem_en && bus_fx.mem_addr == 16'h0106) found = 1;
        end
        check("rst_k3_reached", found, 1);
        rst = 1'b1;
        bus_fx.req = '0;
        #1;
        check("rst_mid_ctl", 32'({bus_fx.busy, bus_fx.mem_en, bus_fx.mem_wr, bus_fx.rsp_valid, bus_fx.rsp_done}), 0);
        check("rst_mid_addr", 32'(bus_fx.mem_addr), 0);
        @(negedge clk);
        check("rst_hold_done", 32'({bus_fx.rsp_valid, bus_fx.rsp_done}), 0);
        rst = 1'b0;
        @(negedge clk);
        v5 = '{1, 1'b0, 16'h0200, 16'h0000, 16'h0200, 12, -1, 1'b0};
        run_txn(v5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
